// File: rtl/prescaled_counter_pkg.sv
// Shared constants for the prescaled counter: direction/end-mode encodings and defaults.
package prescaled_counter_pkg;

  // Default geometry
  localparam int unsigned WIDTH = 4;
  localparam int unsigned DIV_W = 30;

  // up_dn encoding
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // sat_mode encoding
  localparam logic END_WRAP = 1'b0;
  localparam logic END_SAT  = 1'b1;

endpackage

// File: rtl/prescaled_counter_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface prescaled_counter_if #(
  parameter int unsigned WIDTH = prescaled_counter_pkg::WIDTH,
  parameter int unsigned DIV_W = prescaled_counter_pkg::DIV_W
);

  logic             enable;
  logic             up_dn;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [DIV_W-1:0] div;
  logic [WIDTH-1:0] out;
  logic             tick;
  logic             tc;

  modport master (
    output enable, up_dn, sat_mode, load, load_val, div,
    input  out, tick, tc
  );

  modport slave (
    input  enable, up_dn, sat_mode, load, load_val, div,
    output out, tick, tc
  );

endinterface

// File: rtl/prescaled_counter_clk_prescaler.sv
// Clock-enable prescaler: raises step once every div+1 enabled cycles.
module clk_prescaler #(
  parameter int unsigned DIV_W = prescaled_counter_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] r_pre_cnt;
  logic             w_period_done;

  // >= rather than == so a lowered div ends the period at the next edge
  assign w_period_done = (r_pre_cnt >= div);
  assign step          = enable & ~clear & w_period_done;

  // Prescale count: cleared by load, frozen while disabled, restarts after each step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre_cnt <= '0;
    end else if (clear) begin
      r_pre_cnt <= '0;
    end else if (enable) begin
      if (w_period_done) begin
        r_pre_cnt <= '0;
      end else begin
        r_pre_cnt <= r_pre_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// Up/down counter stepped by an on-chip prescaler; wrap or saturate, load, tick and tc pulses.
module prescaled_counter #(
  parameter int unsigned WIDTH = prescaled_counter_pkg::WIDTH,
  parameter int unsigned DIV_W = prescaled_counter_pkg::DIV_W
) (
  input logic              clk,
  input logic              reset,
  prescaled_counter_if.slave bus
);

  import prescaled_counter_pkg::*;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_MIN = '0;

  logic             w_step;
  logic             w_up;
  logic             w_sat;
  logic             w_at_end;
  logic [WIDTH-1:0] w_out_nxt;

  logic [WIDTH-1:0] r_out;
  logic             r_tick;
  logic             r_tc;

  clk_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.enable),
    .clear  (bus.load),
    .div    (bus.div),
    .step   (w_step)
  );

  // Value the counter takes on a step: modulo +/-1, or held when saturating at an end
  always_comb begin
    w_up      = (bus.up_dn == DIR_UP);
    w_sat     = (bus.sat_mode == END_SAT);
    w_at_end  = 1'b0;
    w_out_nxt = r_out;
    if (w_up) begin
      w_at_end  = (r_out == CNT_MAX);
      w_out_nxt = r_out + WIDTH'(1);
    end else begin
      w_at_end  = (r_out == CNT_MIN);
      w_out_nxt = r_out - WIDTH'(1);
    end
    if (w_at_end && w_sat) begin
      w_out_nxt = r_out;
    end
  end

  // Counter and pulse registers: load beats step beats hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out  <= '0;
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
    end else if (bus.load) begin
      r_out  <= bus.load_val;
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
    end else if (w_step) begin
      r_out  <= w_out_nxt;
      r_tick <= 1'b1;
      r_tc   <= w_at_end;
    end else begin
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
    end
  end

  assign bus.out  = r_out;
  assign bus.tick = r_tick;
  assign bus.tc   = r_tc;

endmodule
